decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_if.sv | 50 +++++
 rtl/decode_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_if.sv
// Decode queue handshake bundle: upstream raw-instruction push port, synchronous
// flush, and the downstream decoded head-entry port.
// The master side drives instructions in and consumes decoded entries. The slave
// side is the queue itself.
interface decode_queue_if #(
  parameter int unsigned PC_W = 32
) ();

  // Upstream push port.
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;

  // Discards every held entry.
  logic            flush;

  // Downstream pop port. It presents the head entry, or the live decode when bypassing.
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [31:0]     imm;
  logic [3:0]      alu_op;
  logic            is_jump;
  logic            is_branch;
  logic            mem_read;
  logic            mem_write;
  logic            we;
  logic            writeback;
  logic            illegal;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, opcode, funct3, funct7, rs1, rs2, rd, imm, alu_op,
           is_jump, is_branch, mem_read, mem_write, we, writeback, illegal, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, opcode, funct3, funct7, rs1, rs2, rd, imm, alu_op,
           is_jump, is_branch, mem_read, mem_write, we, writeback, illegal, out_pc
  );

endinterface

// File: rtl/decode_queue.sv
// decode_queue: RV32I decoder followed by a DEPTH-entry FIFO of decoded records.
// Each entry is decoded when it is pushed. The FIFO stores the decoded record
// together with the instruction's PC. The head entry drives the outputs. The
// decoded outputs read as zero while no entry is valid.
// Optional feature: define DECODE_QUEUE_BYPASS_EN to enable the bypass path. When
// the queue is empty, the bypass presents the live decode in the same cycle. An
// entry that is consumed immediately is never written into the FIFO. A flush
// blocks the bypass.

`ifndef ALU_ADD
`define ALU_ADD  4'd1
`define ALU_SUB  4'd2
`define ALU_AND  4'd3
`define ALU_OR   4'd4
`define ALU_XOR  4'd5
`define ALU_SLL  4'd6
`define ALU_SRL  4'd7
`define ALU_SRA  4'd8
`define ALU_SLT  4'd9
`define ALU_SLTU 4'd10
`define ALU_ADDI 4'd11
`endif

module decode_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input logic           clk,
  input logic           rst_n,
  decode_queue_if.slave dq_io
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        is_jump;
    logic        is_branch;
    logic        mem_read;
    logic        mem_write;
    logic        we;
    logic        writeback;
    logic        illegal;
  } dec_t;

  // Register-register ALU selection. The alt input is the funct7[5]-style modifier.
  function automatic logic [3:0] alu_rr(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    op = `ALU_ADD;
    case (f3)
      3'b000: op = alt ? `ALU_SUB : `ALU_ADD;
      3'b111: op = `ALU_AND;
      3'b110: op = `ALU_OR;
      3'b100: op = `ALU_XOR;
      3'b001: op = `ALU_SLL;
      3'b101: op = alt ? `ALU_SRA : `ALU_SRL;
      3'b010: op = `ALU_SLT;
      3'b011: op = `ALU_SLTU;
    endcase
    return op;
  endfunction

  // Full decode of one raw instruction. Illegal encodings leave every control
  // field at zero.
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d        = '0;
    d.opcode = i[6:0];
    d.funct3 = i[14:12];
    d.funct7 = i[31:25];
    d.rs1    = i[19:15];
    d.rs2    = i[24:20];
    d.rd     = i[11:7];
    case (i[6:0])
      OpLui: begin
        d.rs1       = '0;
        d.imm       = {i[31:12], 12'b0};
        d.alu_op    = `ALU_ADDI;
        d.we        = 1'b1;
        d.writeback = 1'b1;
      end
      OpAuipc: begin
        d.imm    = {i[31:12], 12'b0};
        d.alu_op = `ALU_ADD;
        d.we     = 1'b1;
      end
      OpJal: begin
        d.imm       = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        d.is_jump   = 1'b1;
        d.we        = 1'b1;
        d.writeback = 1'b1;
      end
      OpJalr: begin
        d.imm = {{20{i[31]}}, i[31:20]};
        if (i[14:12] == 3'b000) begin
          d.is_jump   = 1'b1;
          d.we        = 1'b1;
          d.writeback = 1'b1;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OpBranch: begin
        d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (i[14:12] inside {3'b010, 3'b011}) begin
          d.illegal = 1'b1;
        end else begin
          d.is_branch = 1'b1;
          d.alu_op    = `ALU_SUB;
        end
      end
      OpLoad: begin
        d.imm = {{20{i[31]}}, i[31:20]};
        if (i[14:12] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          d.alu_op    = `ALU_ADD;
          d.mem_read  = 1'b1;
          d.we        = 1'b1;
          d.writeback = 1'b1;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OpStore: begin
        d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        if (i[14:12] inside {3'b000, 3'b001, 3'b010}) begin
          d.alu_op    = `ALU_ADD;
          d.mem_write = 1'b1;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OpImm: begin
        // Shift-immediate uses imm[10] (inst[30]) to pick SRA over SRL.
        d.imm    = {{20{i[31]}}, i[31:20]};
        d.alu_op = (i[14:12] == 3'b000) ? `ALU_ADDI : alu_rr(i[14:12], i[30]);
        d.we     = 1'b1;
      end
      OpReg: begin
        d.alu_op = alu_rr(i[14:12], i[31:25] == 7'b0100000);
        d.we     = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  dec_t            slot_q [DEPTH];
  logic [PC_W-1:0] pc_q   [DEPTH];

  dec_t            live_dec;
  dec_t            head_dec;
  dec_t            out_dec;
  logic [PC_W-1:0] head_pc;
  logic [PC_W-1:0] out_pc;
  logic            empty;
  logic            bypass;
  logic            out_valid;
  logic            push;
  logic            pop;
  logic            wr_en;

  // Decode the incoming instruction.
  always_comb begin
    live_dec = decode(dq_io.in_inst);
  end

  // Handshake and FIFO next-state. A flush beats any simultaneous push or pop.
  always_comb begin
    empty = (count_q == '0);
`ifdef DECODE_QUEUE_BYPASS_EN
    bypass = empty && dq_io.in_valid && !dq_io.flush;
`else
    bypass = 1'b0;
`endif
    dq_io.in_ready = (count_q < DepthCnt);
    out_valid      = !empty || bypass;
    push           = dq_io.in_valid && dq_io.in_ready && !dq_io.flush;
    pop            = !empty && dq_io.out_ready && !dq_io.flush;
    // A bypassed entry that is consumed at once never occupies a slot.
    wr_en          = push && !(bypass && dq_io.out_ready);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (dq_io.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot storage. It has no reset, and the output mask hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot_q[wr_ptr_q] <= live_dec;
      pc_q[wr_ptr_q]   <= dq_io.in_pc;
    end
  end

  // Head selection and zero-masking while nothing is valid.
  always_comb begin
    head_dec = bypass ? live_dec : slot_q[rd_ptr_q];
    head_pc  = bypass ? dq_io.in_pc : pc_q[rd_ptr_q];
    out_dec  = out_valid ? head_dec : '0;
    out_pc   = out_valid ? head_pc : '0;
  end

  assign dq_io.out_valid = out_valid;
  assign dq_io.opcode    = out_dec.opcode;
  assign dq_io.funct3    = out_dec.funct3;
  assign dq_io.funct7    = out_dec.funct7;
  assign dq_io.rs1       = out_dec.rs1;
  assign dq_io.rs2       = out_dec.rs2;
  assign dq_io.rd        = out_dec.rd;
  assign dq_io.imm       = out_dec.imm;
  assign dq_io.alu_op    = out_dec.alu_op;
  assign dq_io.is_jump   = out_dec.is_jump;
  assign dq_io.is_branch = out_dec.is_branch;
  assign dq_io.mem_read  = out_dec.mem_read;
  assign dq_io.mem_write = out_dec.mem_write;
  assign dq_io.we        = out_dec.we;
  assign dq_io.writeback = out_dec.writeback;
  assign dq_io.illegal   = out_dec.illegal;
  assign dq_io.out_pc    = out_pc;

endmodule
